alu_system_control_unit: RTL and testbench

- Multi-cycle fetch/execute sequencer for the ALU system datapath: RF, ARF (PC/AR/SP), IR, byte-wide memory, ALU and MuxA/B/C.
- Drives every datapath select/enable from a registered state machine.
- Fetches a 16-bit instruction as two bytes (low byte first), then executes it in one cycle.
- Sits beside the ALU system and takes back only IROut and ALUOutFlag.

---
 rtl/alu_system_control_unit.sv | 176 +++++++++++++++++
 tb/tb_alu_system_control_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_system_control_unit.sv
// Multi-cycle fetch/execute controller for the ALU system datapath.
// Optional macro CTRL_SINGLE_STEP_EN: EX returns to IDLE so each Start pulse runs one instruction.
module alu_system_control_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] IROut,
  input  logic [3:0]  ALUOutFlag,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [2:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [4:0]  ALU_FunSel,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [2:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Write,
  output logic        Mem_CS,
  output logic        Mem_WR,
  output logic        ALU_WF,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic [2:0]  State,
  output logic        Halted,
  output logic        Illegal
);

  localparam logic [2:0] FS_LOAD    = 3'b010;
  localparam logic [2:0] FS_INC     = 3'b001;
  localparam logic [4:0] ALU_PASS_A = 5'b10000;
  localparam int         Z_BIT      = 3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FL   = 3'd1,
    S_FH   = 3'd2,
    S_EX   = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t r_state, w_next;
  logic   r_halted, r_illegal;
  logic   w_set_illegal, w_enter_halt;

  logic [3:0] w_op;
  logic [1:0] w_rd, w_rs1, w_rs2;
  logic [4:0] w_fn;
  logic [3:0] w_rd_sel;
  logic       w_unused_flags;

  assign w_op     = IROut[15:12];
  assign w_rd     = IROut[11:10];
  assign w_rs1    = IROut[9:8];
  assign w_rs2    = IROut[7:6];
  assign w_fn     = IROut[4:0];
  assign w_rd_sel = 4'b1000 >> w_rd;
  // Only the zero flag steers control; the rest of the flag word is unused here.
  assign w_unused_flags = ^ALUOutFlag;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_enter_halt)  r_halted  <= 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    RF_OutASel    = 3'd0;
    RF_OutBSel    = 3'd0;
    RF_FunSel     = FS_LOAD;
    RF_RegSel     = 4'd0;
    RF_ScrSel     = 4'd0;
    ALU_FunSel    = 5'd0;
    ARF_OutCSel   = 2'd0;
    ARF_OutDSel   = 2'd0;
    ARF_FunSel    = FS_LOAD;
    ARF_RegSel    = 3'd0;
    IR_LH         = 1'b0;
    IR_Write      = 1'b0;
    Mem_CS        = 1'b1;
    Mem_WR        = 1'b0;
    ALU_WF        = 1'b0;
    MuxASel       = 2'd0;
    MuxBSel       = 2'd0;
    MuxCSel       = 1'b0;
    w_next        = r_state;
    w_set_illegal = 1'b0;
    w_enter_halt  = 1'b0;

    case (r_state)
      S_IDLE: if (Start) w_next = S_FL;
      S_FL, S_FH: begin
        // Fetch byte at PC into the selected IR half, then bump PC.
        Mem_CS      = 1'b0;
        IR_Write    = 1'b1;
        IR_LH       = (r_state == S_FH);
        ARF_OutDSel = 2'b00;
        ARF_RegSel  = 3'b100;
        ARF_FunSel  = FS_INC;
        w_next      = (r_state == S_FL) ? S_FH : S_EX;
      end
      S_EX: begin
`ifdef CTRL_SINGLE_STEP_EN
        w_next = S_IDLE;
`else
        w_next = S_FL;
`endif
        case (w_op)
          4'h0: ;
          4'h1: begin
            MuxASel   = 2'b11;
            RF_FunSel = FS_LOAD;
            RF_RegSel = w_rd_sel;
          end
          4'h2: begin
            RF_OutASel = {1'b0, w_rs1};
            RF_OutBSel = {1'b0, w_rs2};
            ALU_FunSel = w_fn;
            ALU_WF     = 1'b1;
            MuxASel    = 2'b00;
            RF_RegSel  = w_rd_sel;
          end
          4'h3: begin
            ARF_OutDSel = 2'b10;
            Mem_CS      = 1'b0;
            MuxASel     = 2'b10;
            RF_RegSel   = w_rd_sel;
          end
          4'h4: begin
            RF_OutASel  = {1'b0, w_rd};
            ALU_FunSel  = ALU_PASS_A;
            MuxCSel     = 1'b0;
            ARF_OutDSel = 2'b10;
            Mem_CS      = 1'b0;
            Mem_WR      = 1'b1;
          end
          4'h5: begin
            MuxBSel    = 2'b11;
            ARF_RegSel = 3'b010;
            ARF_FunSel = FS_LOAD;
          end
          4'h6: begin
            if (ALUOutFlag[Z_BIT]) begin
              MuxBSel    = 2'b11;
              ARF_RegSel = 3'b100;
              ARF_FunSel = FS_LOAD;
            end
          end
          4'hF: begin
            w_next       = S_HALT;
            w_enter_halt = 1'b1;
          end
          default: w_set_illegal = 1'b1;
        endcase
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  assign State   = r_state;
  assign Halted  = r_halted;
  assign Illegal = r_illegal;

endmodule

// File: tb/tb_alu_system_control_unit.sv
// Self-checking bench for alu_system_control_unit: directed vector table, random decode, reset/halt corners.
module tb_alu_system_control_unit;

  logic        Clock = 1'b0;
  logic        Reset, Start;
  logic [15:0] IROut;
  logic [3:0]  ALUOutFlag;
  logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0]  RF_RegSel, RF_ScrSel;
  logic [4:0]  ALU_FunSel;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel;
  logic [2:0]  ARF_FunSel, ARF_RegSel;
  logic        IR_LH, IR_Write, Mem_CS, Mem_WR, ALU_WF;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel;
  logic [2:0]  State;
  logic        Halted, Illegal;

  typedef struct packed {
    logic [2:0] rf_a, rf_b, rf_fs;
    logic [3:0] rf_reg, rf_scr;
    logic [4:0] alu_fs;
    logic [1:0] arf_c, arf_d;
    logic [2:0] arf_fs, arf_reg;
    logic       ir_lh, ir_wr, cs, wr, wf;
    logic [1:0] muxa, muxb;
    logic       muxc;
  } ctl_t;

  typedef struct {
    logic [15:0] ir;
    logic [3:0]  flag;
    ctl_t        exp;
  } vec_t;

  ctl_t act;
  assign act = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel, ALU_FunSel,
                ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
                IR_LH, IR_Write, Mem_CS, Mem_WR, ALU_WF, MuxASel, MuxBSel, MuxCSel};

  alu_system_control_unit dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .IROut(IROut), .ALUOutFlag(ALUOutFlag),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel), .ALU_FunSel(ALU_FunSel),
    .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel),
    .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH), .IR_Write(IR_Write), .Mem_CS(Mem_CS),
    .Mem_WR(Mem_WR), .ALU_WF(ALU_WF), .MuxASel(MuxASel), .MuxBSel(MuxBSel),
    .MuxCSel(MuxCSel), .State(State), .Halted(Halted), .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_illegal = 1'b0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic ctl_t idle_ctl();
    ctl_t c = '0;
    c.rf_fs  = 3'b010;
    c.arf_fs = 3'b010;
    c.cs     = 1'b1;
    return c;
  endfunction

  function automatic ctl_t fetch_ctl(input logic high);
    ctl_t c = idle_ctl();
    c.cs      = 1'b0;
    c.ir_wr   = 1'b1;
    c.ir_lh   = high;
    c.arf_reg = 3'b100;
    c.arf_fs  = 3'b001;
    return c;
  endfunction

  // Reference decode: what each opcode must ask of the datapath.
  function automatic ctl_t model_ex(input logic [15:0] ir, input logic [3:0] flag);
    ctl_t c = idle_ctl();
    int   rd  = int'(ir[11:10]);
    int   rs1 = int'(ir[9:8]);
    int   rs2 = int'(ir[7:6]);
    logic [3:0] rd_onehot = 4'(8 >> rd);
    case (int'(ir[15:12]))
      1: begin c.muxa = 2'd3; c.rf_reg = rd_onehot; end
      2: begin
        c.rf_a = 3'(rs1); c.rf_b = 3'(rs2); c.alu_fs = ir[4:0];
        c.wf = 1'b1; c.rf_reg = rd_onehot;
      end
      3: begin c.arf_d = 2'd2; c.cs = 1'b0; c.muxa = 2'd2; c.rf_reg = rd_onehot; end
      4: begin
        c.rf_a = 3'(rd); c.alu_fs = 5'd16; c.arf_d = 2'd2; c.cs = 1'b0; c.wr = 1'b1;
      end
      5: begin c.muxb = 2'd3; c.arf_reg = 3'b010; end
      6: if (flag[3]) begin c.muxb = 2'd3; c.arf_reg = 3'b100; end
      default: ;
    endcase
    return c;
  endfunction

  // Runs FL, FH, EX for one instruction; entered just after the edge into FL.
  task automatic run_instr(input string name, input logic [15:0] ir, input logic [3:0] flag,
                           input ctl_t exp_ex);
    logic [2:0] exp_next;
    IROut = 16'($urandom); ALUOutFlag = 4'($urandom); #1;
    check({name, ".fl_state"}, 64'(State), 64'd1);
    check({name, ".fl_ctl"}, 64'(act), 64'(fetch_ctl(1'b0)));
    tick();
    check({name, ".fh_state"}, 64'(State), 64'd2);
    check({name, ".fh_ctl"}, 64'(act), 64'(fetch_ctl(1'b1)));
    tick();
    IROut = ir; ALUOutFlag = flag; #1;
    check({name, ".ex_state"}, 64'(State), 64'd3);
    check({name, ".ex_ctl"}, 64'(act), 64'(exp_ex));
    if (ir[15:12] >= 4'h7 && ir[15:12] <= 4'hE) exp_illegal = 1'b1;
`ifdef CTRL_SINGLE_STEP_EN
    exp_next = (ir[15:12] == 4'hF) ? 3'd4 : 3'd0;
`else
    exp_next = (ir[15:12] == 4'hF) ? 3'd4 : 3'd1;
`endif
    tick();
    check({name, ".next_state"}, 64'(State), 64'(exp_next));
    check({name, ".illegal"}, 64'(Illegal), 64'(exp_illegal));
    check({name, ".halted"}, 64'(Halted), 64'(ir[15:12] == 4'hF));
    if (exp_next == 3'd0) begin
      Start = 1'b1; tick(); Start = 1'b0;
    end
  endtask

  vec_t vecs[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ctl_t e;
    // Directed decode table: hand-derived expectations per opcode.
    e = idle_ctl();                                                       vecs[0] = '{16'h0000, 4'h0, e};
    e = idle_ctl(); e.muxa = 2'd3; e.rf_reg = 4'b0010;                    vecs[1] = '{16'h182A, 4'h0, e};
    e = idle_ctl(); e.rf_a = 3'd1; e.rf_b = 3'd1; e.alu_fs = 5'h04; e.wf = 1'b1; e.rf_reg = 4'b0100;
                                                                          vecs[2] = '{16'h2564, 4'h0, e};
    e = idle_ctl(); e.arf_d = 2'd2; e.cs = 1'b0; e.muxa = 2'd2; e.rf_reg = 4'b0001;
                                                                          vecs[3] = '{16'h3C00, 4'h0, e};
    e = idle_ctl(); e.alu_fs = 5'b10000; e.arf_d = 2'd2; e.cs = 1'b0; e.wr = 1'b1;
                                                                          vecs[4] = '{16'h4000, 4'h0, e};
    e = idle_ctl(); e.muxb = 2'd3; e.arf_reg = 3'b010;                    vecs[5] = '{16'h5000, 4'h0, e};
    e = idle_ctl(); e.muxb = 2'd3; e.arf_reg = 3'b100;                    vecs[6] = '{16'h6040, 4'h8, e};
    e = idle_ctl();                                                       vecs[7] = '{16'h6040, 4'h7, e};
    e = idle_ctl(); e.rf_a = 3'd3; e.rf_b = 3'd2; e.alu_fs = 5'h1F; e.wf = 1'b1; e.rf_reg = 4'b0010;
                                                                          vecs[8] = '{16'h2B9F, 4'h0, e};
    e = idle_ctl();                                                       vecs[9] = '{16'h7123, 4'hF, e};

    Reset = 1'b0; Start = 1'b0; IROut = 16'h0; ALUOutFlag = 4'h0;
    tick();
    Reset = 1'b1; #1;
    check("reset.state", 64'(State), 64'd0);
    check("reset.ctl", 64'(act), 64'(idle_ctl()));
    tick();
    check("idle_hold.state", 64'(State), 64'd0);

    // Reset in the middle of a fetch.
    Start = 1'b1; tick(); Start = 1'b0;
    tick();
    check("midfh.pre_state", 64'(State), 64'd2);
    Reset = 1'b0; tick(); Reset = 1'b1;
    check("midfh.state", 64'(State), 64'd0);
    check("midfh.ctl", 64'(act), 64'(idle_ctl()));
    check("midfh.halted", 64'(Halted), 64'd0);
    check("midfh.illegal", 64'(Illegal), 64'd0);

    Start = 1'b1; tick(); Start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      run_instr($sformatf("vec%0d", i), vecs[i].ir, vecs[i].flag, vecs[i].exp);
    end

    for (int i = 0; i < 40; i++) begin
      logic [15:0] ir   = 16'($urandom);
      logic [3:0]  flag = 4'($urandom);
      if (ir[15:12] == 4'hF) ir[15:12] = 4'h6;
      run_instr($sformatf("rnd%0d", i), ir, flag, model_ex(ir, flag));
    end

    run_instr("hlt", 16'hF000, 4'h0, idle_ctl());
    Start = 1'b1;
    repeat (5) tick();
    check("halt.hold_state", 64'(State), 64'd4);
    check("halt.hold_halted", 64'(Halted), 64'd1);
    check("halt.ctl", 64'(act), 64'(idle_ctl()));
    Start = 1'b0;
    Reset = 1'b0; tick(); Reset = 1'b1;
    check("halt.reset_state", 64'(State), 64'd0);
    check("halt.reset_halted", 64'(Halted), 64'd0);
    check("halt.reset_illegal", 64'(Illegal), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
